// File: rtl/serial_add_unit.sv
// Bit-serial unsigned adder: two half-adder cells plus a registered carry form one full-add step per clock.
// Start to done is WIDTH+1 cycles; start is accepted only in IDLE, and start requests at any other time are dropped.

module half_adder (
    input  logic a,
    input  logic b,
    output logic sum,
    output logic carry
);
    assign sum   = a ^ b;
    assign carry = a & b;
endmodule

module serial_add_unit #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);
    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] SHIFT = 2'd1;
    localparam logic [1:0] DONE  = 2'd2;

    logic [1:0]       state;
    logic [WIDTH-1:0] a_sr;
    logic [WIDTH-1:0] b_sr;
    logic [WIDTH-1:0] res_sr;
    logic             carry;
    logic [CW-1:0]    cnt;

    logic             p, g, s, t, c_next;
    logic [WIDTH:0]   res_cat;
    logic [WIDTH-1:0] res_next;

    // First cell adds the operand bits, second folds in the carry.
    half_adder u_ha_op (.a(a_sr[0]), .b(b_sr[0]), .sum(p), .carry(g));
    half_adder u_ha_c  (.a(p),       .b(carry),   .sum(s), .carry(t));

    assign c_next   = g | t;
    assign res_cat  = {s, res_sr};
    assign res_next = res_cat[WIDTH:1];

    assign busy = (state == SHIFT);
    assign done = (state == DONE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            a_sr   <= '0;
            b_sr   <= '0;
            res_sr <= '0;
            carry  <= 1'b0;
            cnt    <= '0;
            sum    <= '0;
            cout   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        a_sr   <= a;
                        b_sr   <= b;
                        res_sr <= '0;
                        carry  <= 1'b0;
                        cnt    <= '0;
                        state  <= SHIFT;
                    end
                end
                SHIFT: begin
                    a_sr   <= a_sr >> 1;
                    b_sr   <= b_sr >> 1;
                    res_sr <= res_next;
                    carry  <= c_next;
                    cnt    <= cnt + 1'b1;
                    // Outputs only move on the final bit so they hold the old result while busy.
                    if (cnt == LAST) begin
                        sum   <= res_next;
                        cout  <= c_next;
                        state <= DONE;
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_serial_add_unit.sv
// Directed bench for serial_add_unit: an 8-bit instance plus a 1-bit instance sharing clock and reset.
module tb_serial_add_unit;
    logic       clk;
    logic       rst_n;
    logic       start;
    logic [7:0] a, b, sum;
    logic       busy, done, cout;

    logic       start1;
    logic [0:0] a1, b1, sum1;
    logic       busy1, done1, cout1;

    int         n_checks;
    int         n_fail;
    logic [7:0] prev_sum;
    logic       prev_cout;

    serial_add_unit #(.WIDTH(8)) u_dut (
        .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b),
        .busy(busy), .done(done), .sum(sum), .cout(cout)
    );

    serial_add_unit #(.WIDTH(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .start(start1), .a(a1), .b(b1),
        .busy(busy1), .done(done1), .sum(sum1), .cout(cout1)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One full 8-bit operation; inputs change on negedges, outputs sampled on negedges.
    task automatic do_op(input logic [7:0] av, input logic [7:0] bv,
                         input logic [7:0] es, input logic ec, input string tag);
        int n;
        a = av; b = bv; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        n = 0;
        while (busy === 1'b1 && n < 20) begin
            chk({tag, "_hold_sum"},  32'(sum),  32'(prev_sum));
            chk({tag, "_hold_cout"}, 32'(cout), 32'(prev_cout));
            chk({tag, "_no_done"},   32'(done), 32'h0);
            n++;
            @(negedge clk);
        end
        chk({tag, "_busy_len"}, 32'(n),    32'd8);
        chk({tag, "_done"},     32'(done), 32'h1);
        chk({tag, "_busy_off"}, 32'(busy), 32'h0);
        chk({tag, "_sum"},      32'(sum),  32'(es));
        chk({tag, "_cout"},     32'(cout), 32'(ec));
        @(negedge clk);
        chk({tag, "_done_1cyc"}, 32'(done), 32'h0);
        prev_sum  = es;
        prev_cout = ec;
    endtask

    task automatic do_op1(input logic av, input logic bv, input logic es, input logic ec,
                          input string tag);
        a1 = av; b1 = bv; start1 = 1'b1;
        @(negedge clk);
        start1 = 1'b0;
        chk({tag, "_busy"},    32'(busy1), 32'h1);
        chk({tag, "_no_done"}, 32'(done1), 32'h0);
        @(negedge clk);
        chk({tag, "_busy_off"}, 32'(busy1), 32'h0);
        chk({tag, "_done"},     32'(done1), 32'h1);
        chk({tag, "_sum"},      32'(sum1),  32'(es));
        chk({tag, "_cout"},     32'(cout1), 32'(ec));
        @(negedge clk);
        chk({tag, "_done_1cyc"}, 32'(done1), 32'h0);
    endtask

    initial begin
        int ndone;
        int nbusy;
        n_checks = 0; n_fail = 0;
        prev_sum = 8'h00; prev_cout = 1'b0;
        rst_n = 1'b0; start = 1'b0; a = '0; b = '0;
        start1 = 1'b0; a1 = '0; b1 = '0;

        // Reset state
        #2;
        chk("rst_busy", 32'(busy), 32'h0);
        chk("rst_done", 32'(done), 32'h0);
        chk("rst_sum",  32'(sum),  32'h0);
        chk("rst_cout", 32'(cout), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("idle_after_rst", 32'(busy), 32'h0);

        // Basic and carry-heavy additions
        do_op(8'h3C, 8'h0F, 8'h4B, 1'b0, "t1");
        do_op(8'hFF, 8'h01, 8'h00, 1'b1, "t2a");
        do_op(8'hFF, 8'hFF, 8'hFE, 1'b1, "t2b");

        // Start re-pulsed mid-operation must be ignored
        a = 8'h05; b = 8'h03; start = 1'b1;
        ndone = 0; nbusy = 0;
        for (int i = 1; i <= 14; i++) begin
            @(negedge clk);
            start = 1'b0;
            if (i == 2) begin
                a = 8'h11; b = 8'h22; start = 1'b1;
            end
            if (busy) nbusy++;
            if (done) begin
                ndone++;
                chk("t3_done_cycle", 32'(i), 32'd9);
            end
            chk("t3_excl", 32'(busy & done), 32'h0);
        end
        chk("t3_busy_cnt", 32'(nbusy), 32'd8);
        chk("t3_done_cnt", 32'(ndone), 32'd1);
        chk("t3_sum",  32'(sum),  32'h08);
        chk("t3_cout", 32'(cout), 32'h0);

        // Start held high: back-to-back operations every 10 cycles
        a = 8'h01; b = 8'h01; start = 1'b1;
        ndone = 0;
        for (int i = 1; i <= 30; i++) begin
            @(negedge clk);
            if (i == 12) a = 8'h7F;
            if (done) begin
                chk("t4_done_cycle", 32'(i), 32'(9 + 10 * ndone));
                // Third operation captured a=0x7F after the change
                chk("t4_sum", 32'(sum), (ndone < 2) ? 32'h02 : 32'h80);
                chk("t4_cout", 32'(cout), 32'h0);
                ndone++;
            end
            chk("t4_excl", 32'(busy & done), 32'h0);
            if (i == 30) start = 1'b0;
        end
        chk("t4_done_cnt", 32'(ndone), 32'd3);
        @(negedge clk);
        @(negedge clk);
        chk("t4_idle", 32'(busy), 32'h0);

        // Asynchronous reset in the middle of SHIFT
        a = 8'hAA; b = 8'h55; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int i = 2; i <= 4; i++) @(negedge clk);
        chk("t5_busy_pre", 32'(busy), 32'h1);
        chk("t5_sum_pre",  32'(sum),  32'h80);
        rst_n = 1'b0;
        #1;
        chk("t5_busy", 32'(busy), 32'h0);
        chk("t5_done", 32'(done), 32'h0);
        chk("t5_sum",  32'(sum),  32'h0);
        chk("t5_cout", 32'(cout), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        ndone = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (done || busy) ndone++;
        end
        chk("t5_no_restart", 32'(ndone), 32'd0);
        prev_sum = 8'h00; prev_cout = 1'b0;
        do_op(8'hAA, 8'h55, 8'hFF, 1'b0, "t5_fresh");

        // WIDTH=1 instance
        do_op1(1'b1, 1'b1, 1'b0, 1'b1, "t6a");
        do_op1(1'b1, 1'b0, 1'b1, 1'b0, "t6b");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/serial_add_unit.md
Name: serial_add_unit

Overview:
- Bit-serial N-bit adder built around the team's 1-bit half-adder sum/carry cell. Two half-adder cells plus a registered carry form a full-add step.
- Accepts two parallel operands on a start pulse and shifts them LSB-first through the adder, one bit per clock.
- Returns a parallel sum, carry-out and a one-cycle done pulse.
- Sits directly downstream of the half-adder stage and consumes its sum/carry outputs as its per-bit datapath.

Parameters:
- WIDTH, 8, operand and sum width in bits (legal range 1..32).

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  request to begin an addition; sampled on a rising clk edge.
- a  input  WIDTH  operand A; captured when start is accepted.
- b  input  WIDTH  operand B; captured when start is accepted.
- busy  output  1  high while an addition is in progress.
- done  output  1  one-cycle pulse when sum and cout become valid.
- sum  output  WIDTH  registered result, A+B modulo 2^WIDTH.
- cout  output  1  registered carry-out of the final bit.

Behaviour:
- Interface: one clock (clk); reset rst_n is asynchronous and active-low. All state flops clear immediately on rst_n low, independent of clk.
- Reset values: busy=0, done=0, sum=0, cout=0, FSM=IDLE, internal carry=0, bit counter=0, shift registers=0.
- FSM states and transitions:
  - IDLE: start=1 at an edge loads a and b into shift registers, clears the internal carry and counter, and moves to SHIFT.
  - SHIFT: each cycle computes s = a_sr[0]^b_sr[0]^c and c_next = (a_sr[0]&b_sr[0]) | (c&(a_sr[0]^b_sr[0])). Both shift registers shift right by one. s enters the MSB of the result shift register. The counter increments. After WIDTH SHIFT cycles, moves to DONE.
  - DONE: lasts one cycle, then returns unconditionally to IDLE.
- Timing: start sampled at edge k gives busy=1 for cycles k+1..k+WIDTH and done=1 for cycle k+WIDTH+1 only. sum and cout update at the edge that enters DONE. Total latency from start to done is WIDTH+1 cycles.
- Result hold: sum and cout hold the previous result throughout busy. They change only when DONE is entered and hold until the next completion.
- Handshake: start is accepted only in IDLE. start during SHIFT or DONE is ignored, not queued. If start is held continuously high, a new operation begins on the first edge in IDLE, one cycle after done.
- Operand capture: a and b are sampled only on the accepting edge. Later changes to a/b have no effect on the operation in flight.
- Arithmetic: unsigned. sum = (A+B)[WIDTH-1:0], cout = (A+B)[WIDTH]. The counter is wide enough to hold WIDTH.
- Boundaries:
  - WIDTH=1: exactly one SHIFT cycle.
  - All-ones plus one: carry propagates across every bit.
  - rst_n low mid-SHIFT: aborts the operation, no done pulse, sum/cout go to 0.
  - rst_n deassertion: synchronised externally. The block must not start on the same edge as rst_n deassertion unless start=1 is sampled at that edge.
- busy and done are never high in the same cycle.

Test Plan:
1. WIDTH=8, start with a=0x3C, b=0x0F -> busy high 8 cycles, done pulse on cycle 9, sum=0x4B, cout=0.
2. a=0xFF, b=0x01 -> sum=0x00, cout=1. Then a=0xFF, b=0xFF -> sum=0xFE, cout=1.
3. start re-pulsed with a=0x11, b=0x22 during busy of a 0x05+0x03 operation -> second start ignored, result sum=0x08, only one done pulse.
4. start held high continuously with a=0x01, b=0x01 -> done every 10 cycles, sum=0x02. Changing a to 0x7F mid-operation does not alter the in-flight result.
5. rst_n pulsed low at SHIFT cycle 4 of 0xAA+0x55 -> busy, done, sum and cout all 0 immediately. FSM returns to IDLE, and a fresh start then gives sum=0xFF, cout=0.
6. WIDTH=1 build: a=1, b=1 -> busy 1 cycle, done next cycle, sum=0, cout=1. a=1, b=0 -> sum=1, cout=0.
